// File: rtl/masked_write_ctrl.sv
// masked_write_ctrl
//
// Read-modify-write sequencer for a word-only memory port. It accepts one
// masked write request, reads the target word, merges the new data into the
// old word under the bit mask, and writes the merged word back.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     request handshake; ready only while idle
//   req_addr/data/mask      request word address, new data, bit mask
//                           (mask bit 1 = take new bit, 0 = keep old bit)
//   busy                    transaction in progress
//   done                    one-cycle completion pulse
//   mem_addr                memory word address, stable for the transaction
//   mem_rd / mem_wr         read / write strobes, held until mem_ack
//   mem_wdata               write data, valid while mem_wr
//   mem_rdata / mem_ack     read data and completion from memory
//
// Configuration
//   MASKED_WRITE_FULL_BYPASS_EN  when defined, an all-ones mask skips the
//                                read and merge and writes req_data directly.

// Keeps only the bits of data_i selected by mask_i.
module mask_filter (
    input  logic [31:0] data_i,
    input  logic [31:0] mask_i,
    output logic [31:0] data_o
);
    assign data_o = data_i & mask_i;
endmodule

module masked_write_ctrl #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [31:0]           req_mask,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           mask_q, mask_d;
    logic [31:0]           old_q, old_d;
    logic [31:0]           wdata_q, wdata_d;

    logic [31:0]           new_bits;
    logic [31:0]           kept_bits;

    // New bits come from the request where the mask is set; old bits survive
    // where it is clear.
    mask_filter u_new_filter (
        .data_i (data_q),
        .mask_i (mask_q),
        .data_o (new_bits)
    );

    mask_filter u_old_filter (
        .data_i (old_q),
        .mask_i (~mask_q),
        .data_o (kept_bits)
    );

    // Next-state and datapath register updates. wdata is loaded with the raw
    // request data on accept so the bypass path can write it without a merge.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        old_d   = old_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    data_d  = req_data;
                    mask_d  = req_mask;
                    wdata_d = req_data;
                    if (req_mask == '0) begin
                        state_d = DONE;
                    end
`ifdef MASKED_WRITE_FULL_BYPASS_EN
                    else if (&req_mask) begin
                        state_d = WRITE;
                    end
`endif
                    else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (mem_ack) begin
                    old_d   = mem_rdata;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                wdata_d = new_bits | kept_bits;
                state_d = WRITE;
            end
            WRITE: begin
                if (mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            old_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            old_q   <= old_d;
            wdata_q <= wdata_d;
        end
    end

    // All handshake outputs are pure decodes of registered state.
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign mem_rd    = (state_q == READ);
    assign mem_wr    = (state_q == WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_masked_write_ctrl.sv
// Testbench for masked_write_ctrl: a behavioural word memory with
// programmable ack latency, a write scoreboard, a table of single requests,
// and hand-written reset and back-to-back sequences.
module tb_masked_write_ctrl;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic [31:0]   req_mask;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    masked_write_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_mask  (req_mask),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Memory model state and protocol monitors.
    bit [31:0]     mem [int];
    bit [31:0]     ref_mem [int];
    int            rd_dly = 0;
    int            wr_dly = 0;
    int            wait_cnt = 0;
    int            rd_acks = 0;
    int            wr_acks = 0;
    int            addr_err = 0;
    int            overlap_err = 0;
    logic          prev_strobe = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_e;

    // Results of the most recent apply_stimulus call.
    int r_done_cyc;
    int r_done_cnt;
    int r_rd_cyc;
    int r_wr_cyc;
    logic r_ready_after;
    logic r_busy_at1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   old_word;
        logic [31:0]   data;
        logic [31:0]   mask;
        int            rd_dly;
        int            wr_dly;
        int            done_cyc;
        int            rd_cyc;
        int            wr_cyc;
        logic [31:0]   final_word;
    } vec_t;

    vec_t vecs [6];

    // Memory responds on the falling edge so the ack and read data are stable
    // for the next rising edge; a zero delay acks in the strobe's first cycle.
    // A write is committed when its ack is raised and checked against the
    // scoreboard at that point.
    always @(negedge clk) begin
        if (mem_rd && mem_wr) overlap_err++;
        if (prev_strobe && (mem_rd || mem_wr) && mem_addr != prev_addr) addr_err++;
        prev_strobe = mem_rd || mem_wr;
        prev_addr   = mem_addr;
        if (rst_n && (mem_rd || mem_wr)) begin
            if (wait_cnt >= (mem_rd ? rd_dly : wr_dly)) begin
                mem_ack = 1'b1;
                if (mem_rd) begin
                    mem_rdata = mem[int'(mem_addr)];
                    rd_acks++;
                end else begin
                    wr_acks++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("[TB] FAIL unexpected_write addr=%h data=%h required=no write", mem_addr, mem_wdata);
                    end else begin
                        exp_e = exp_q.pop_front();
                        if (exp_e.addr !== mem_addr || exp_e.data !== mem_wdata) begin
                            n_bad++;
                            $display("[TB] FAIL write_data actual=%h@%h required=%h@%h", mem_wdata, mem_addr, exp_e.data, exp_e.addr);
                        end
                    end
                    mem[int'(mem_addr)] = mem_wdata;
                end
            end else begin
                mem_ack = 1'b0;
            end
            wait_cnt++;
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_vec++;
        if (actual !== required) begin
            n_bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] w);
        mem[int'(a)]     = w;
        ref_mem[int'(a)] = w;
    endtask

    // Pushes the expected write (if any) computed from the reference image.
    task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] m);
        wr_t e;
        if (m != 32'h0) begin
            e.addr = a;
            e.data = (ref_mem[int'(a)] & ~m) | (d & m);
            exp_q.push_back(e);
            ref_mem[int'(a)] = e.data;
        end
    endtask

    // Presents one request in cycle 0 (called just after a rising edge while
    // idle), scrambles the request inputs once accepted, and records the
    // cycle of done, strobe-high cycles, and ready in the cycle after done.
    task automatic apply_stimulus(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] m);
        expect_write(a, d, m);
        req_addr  = a;
        req_data  = d;
        req_mask  = m;
        req_valid = 1'b1;
        r_done_cyc    = -1;
        r_done_cnt    = 0;
        r_rd_cyc      = 0;
        r_wr_cyc      = 0;
        r_ready_after = 1'b0;
        r_busy_at1    = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                req_valid  = 1'b0;
                req_addr   = ~a;
                req_data   = ~d;
                req_mask   = ~m;
                r_busy_at1 = busy;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
            end
            if (mem_rd) r_rd_cyc++;
            if (mem_wr) r_wr_cyc++;
            if (r_done_cyc >= 0 && cyc == r_done_cyc + 1) begin
                r_ready_after = req_ready;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d1;
        int acc2;
        int d2;
        int seen_wr;

        vecs[0] = '{16'h0010, 32'h12345678, 32'hAABBCCDD, 32'hFF00FF00, 0, 0, 4, 1, 1, 32'hAA34CC78};
        vecs[1] = '{16'h0010, 32'h12345678, 32'hAABBCCDD, 32'hFF00FF00, 3, 2, 9, 4, 3, 32'hAA34CC78};
        vecs[2] = '{16'h0020, 32'h55555555, 32'h99999999, 32'h00000000, 0, 0, 1, 0, 0, 32'h55555555};
`ifdef MASKED_WRITE_FULL_BYPASS_EN
        vecs[3] = '{16'h0030, 32'h01020304, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0, 2, 0, 1, 32'hDEADBEEF};
`else
        vecs[3] = '{16'h0030, 32'h01020304, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0, 4, 1, 1, 32'hDEADBEEF};
`endif
        vecs[4] = '{16'hFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1, 0, 5, 2, 1, 32'h00000001};
        vecs[5] = '{16'h0000, 32'hCAFEF00D, 32'h00000000, 32'hFFFF0000, 0, 1, 5, 1, 2, 32'h0000F00D};

        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_mask  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        rst_n     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_req_ready", 32'(req_ready), 32'h1);
        check_output("reset_busy",      32'(busy),      32'h0);
        check_output("reset_done",      32'(done),      32'h0);
        check_output("reset_mem_rd",    32'(mem_rd),    32'h0);
        check_output("reset_mem_wr",    32'(mem_wr),    32'h0);
        check_output("reset_mem_addr",  32'(mem_addr),  32'h0);
        check_output("reset_mem_wdata", mem_wdata,      32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] table-driven single requests");
        foreach (vecs[i]) begin
            preload(vecs[i].addr, vecs[i].old_word);
            rd_dly      = vecs[i].rd_dly;
            wr_dly      = vecs[i].wr_dly;
            addr_err    = 0;
            overlap_err = 0;
            apply_stimulus(vecs[i].addr, vecs[i].data, vecs[i].mask);
            check_output($sformatf("v%0d_done_cycle", i), 32'(r_done_cyc), 32'(vecs[i].done_cyc));
            check_output($sformatf("v%0d_done_width", i), 32'(r_done_cnt), 32'h1);
            check_output($sformatf("v%0d_ready_after", i), 32'(r_ready_after), 32'h1);
            check_output($sformatf("v%0d_busy_c1", i), 32'(r_busy_at1), 32'h1);
            check_output($sformatf("v%0d_rd_cycles", i), 32'(r_rd_cyc), 32'(vecs[i].rd_cyc));
            check_output($sformatf("v%0d_wr_cycles", i), 32'(r_wr_cyc), 32'(vecs[i].wr_cyc));
            check_output($sformatf("v%0d_mem_word", i), mem[int'(vecs[i].addr)], vecs[i].final_word);
            check_output($sformatf("v%0d_addr_stable", i), 32'(addr_err), 32'h0);
            check_output($sformatf("v%0d_strobe_overlap", i), 32'(overlap_err), 32'h0);
        end

        $display("[TB] reset during a pending write");
        preload(16'h0040, 32'h11111111);
        rd_dly  = 0;
        wr_dly  = 20;
        wr_acks = 0;
        expect_write(16'h0040, 32'h22222222, 32'h0000FFFF);
        req_addr  = 16'h0040;
        req_data  = 32'h22222222;
        req_mask  = 32'h0000FFFF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen_wr = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (mem_wr) begin
                seen_wr = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_output("rst_reached_write", 32'(seen_wr), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("rst_mem_wr_drop", 32'(mem_wr),    32'h0);
        check_output("rst_busy",        32'(busy),      32'h0);
        check_output("rst_ready",       32'(req_ready), 32'h1);
        exp_q.delete();
        ref_mem[int'(16'h0040)] = 32'h11111111;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_output("rst_mem_unchanged", mem[int'(16'h0040)], 32'h11111111);
        check_output("rst_no_write",      32'(wr_acks),         32'h0);
        wr_dly = 0;
        apply_stimulus(16'h0040, 32'h22222222, 32'h0000FFFF);
        check_output("rst_after_done_cycle", 32'(r_done_cyc), 32'd4);
        check_output("rst_after_mem_word",   mem[int'(16'h0040)], 32'h11112222);

        $display("[TB] back-to-back requests held on req_valid");
        preload(16'h0050, 32'hFFFFFFFF);
        expect_write(16'h0050, 32'h00000000, 32'hF0F0F0F0);
        expect_write(16'h0050, 32'h00001234, 32'h0000FFFF);
        d1   = -1;
        acc2 = -1;
        d2   = -1;
        req_addr  = 16'h0050;
        req_data  = 32'h00000000;
        req_mask  = 32'hF0F0F0F0;
        req_valid = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                req_data = 32'h00001234;
                req_mask = 32'h0000FFFF;
            end
            if (acc2 >= 0 && cyc == acc2 + 1) req_valid = 1'b0;
            if (done) begin
                if (d1 < 0) d1 = cyc;
                else if (d2 < 0) d2 = cyc;
            end
            if (req_ready && acc2 < 0 && d1 >= 0) acc2 = cyc;
            if (d2 >= 0) break;
        end
        req_valid = 1'b0;
        check_output("b2b_first_done",   32'(d1),   32'd4);
        check_output("b2b_second_accept", 32'(acc2), 32'd5);
        check_output("b2b_second_done",  32'(d2),   32'd9);
        check_output("b2b_mem_word",     mem[int'(16'h0050)], 32'h0F0F1234);

        repeat (2) @(posedge clk);
        #1;
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
